// File: rtl/mc_ctrl_pkg.sv
// Shared control definitions for the multicycle MIPS datapath:
// state encodings, opcodes, ALUOp and mux select codes, per-state control word.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECUTE  = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_ADDIEXEC = 4'd10,
    S_ADDIWB   = 4'd11,
    S_JUMP     = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BRIMM = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       iord;
    logic       alusrca;
    logic       regdst;
    logic       memtoreg;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       pcwrite;
    logic       branch;
  } ctrl_t;

  function automatic logic op_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) ||
           (op == OP_SW) || (op == OP_BEQ) ||
           (op == OP_ADDI) || (op == OP_J);
  endfunction

  // Moore control word for a state; anything not set stays 0.
  function automatic ctrl_t ctrl_decode(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.irwrite = 1'b1;
        c.pcwrite = 1'b1;
        c.alusrcb = SRCB_FOUR;
      end
      S_DECODE: begin
        c.alusrcb = SRCB_BRIMM;
      end
      S_MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
      end
      S_MEMREAD: begin
        c.iord = 1'b1;
      end
      S_MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      S_MEMWRITE: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      S_EXECUTE: begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      S_BRANCH: begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_SUB;
        c.pcsrc   = PCSRC_ALUOUT;
        c.branch  = 1'b1;
      end
      S_ADDIEXEC: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
      end
      S_ADDIWB: begin
        c.regwrite = 1'b1;
      end
      S_JUMP: begin
        c.pcsrc   = PCSRC_JUMP;
        c.pcwrite = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_main_fsm.sv
// Multicycle MIPS main control FSM; memory wait handshake enabled by
// defining MC_MEM_WAIT_EN (adds the MemReady port).
module mc_main_fsm
  import mc_ctrl_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] Opcode,
  input  logic       Zero,
`ifdef MC_MEM_WAIT_EN
  input  logic       MemReady,
`endif
  output logic       IorD,
  output logic       ALUSrcA,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [1:0] ALUOp,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       PCWrite,
  output logic       Branch,
  output logic       PCEn,
  output logic       Illegal,
  output logic [3:0] State
);

  logic   mem_rdy;
  logic   wr_ok;
  state_e state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;

`ifdef MC_MEM_WAIT_EN
  assign mem_rdy = MemReady;
`else
  assign mem_rdy = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:    state_d = S_FETCH;
      S_FETCH:    if (mem_rdy) state_d = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (Opcode == OP_SW) state_d = S_MEMWRITE;
        else                 state_d = S_MEMREAD;
      end
      S_MEMREAD:  if (mem_rdy) state_d = S_MEMWB;
      S_MEMWRITE: if (mem_rdy) state_d = S_FETCH;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ADDIEXEC: state_d = S_ADDIWB;
      S_MEMWB,
      S_ALUWB,
      S_ADDIWB,
      S_BRANCH,
      S_JUMP:     state_d = S_FETCH;
      default:    state_d = S_RESET;
    endcase
  end

  // Control word is registered from the next state so it lines up with state_q.
  assign ctrl_d = ctrl_decode(state_d);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_RESET;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // A stalled fetch must not advance PC or load IR.
  assign wr_ok = (state_q != S_FETCH) || mem_rdy;

  assign IorD     = ctrl_q.iord;
  assign ALUSrcA  = ctrl_q.alusrca;
  assign RegDst   = ctrl_q.regdst;
  assign MemtoReg = ctrl_q.memtoreg;
  assign ALUSrcB  = ctrl_q.alusrcb;
  assign PCSrc    = ctrl_q.pcsrc;
  assign ALUOp    = ctrl_q.aluop;
  assign IRWrite  = ctrl_q.irwrite & wr_ok;
  assign MemWrite = ctrl_q.memwrite;
  assign RegWrite = ctrl_q.regwrite;
  assign PCWrite  = ctrl_q.pcwrite & wr_ok;
  assign Branch   = ctrl_q.branch;
  assign PCEn     = PCWrite | (Branch & Zero);
  assign Illegal  = (state_q == S_DECODE) & ~op_legal(Opcode);
  assign State    = state_q;

endmodule

// File: tb/tb_mc_main_fsm.sv
// Directed self-checking bench for mc_main_fsm; build with MC_MEM_WAIT_EN
// defined to also exercise the memory wait handshake.
module tb_mc_main_fsm;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [5:0] Opcode = 6'b000000;
  logic       Zero = 1'b0;
`ifdef MC_MEM_WAIT_EN
  logic       MemReady = 1'b1;
`endif
  logic       IorD, ALUSrcA, RegDst, MemtoReg;
  logic [1:0] ALUSrcB, PCSrc, ALUOp;
  logic       IRWrite, MemWrite, RegWrite, PCWrite, Branch;
  logic       PCEn, Illegal;
  logic [3:0] State;

  int pass_cnt = 0;
  int total_cnt = 0;

  mc_main_fsm dut (
    .CLK(CLK), .RST(RST), .Opcode(Opcode), .Zero(Zero),
`ifdef MC_MEM_WAIT_EN
    .MemReady(MemReady),
`endif
    .IorD(IorD), .ALUSrcA(ALUSrcA), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
    .ALUOp(ALUOp), .IRWrite(IRWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .PCWrite(PCWrite), .Branch(Branch),
    .PCEn(PCEn), .Illegal(Illegal), .State(State)
  );

  always #5 CLK = ~CLK;

  // {IorD,ALUSrcA,RegDst,MemtoReg,ALUSrcB,PCSrc,ALUOp,IRW,MemW,RegW,PCW,Br}
  logic [14:0] outs;
  assign outs = {IorD, ALUSrcA, RegDst, MemtoReg, ALUSrcB, PCSrc,
                 ALUOp, IRWrite, MemWrite, RegWrite, PCWrite, Branch};

  function automatic logic [14:0] exp_outs(input int s);
    case (s)
      1:  return 15'b0000_01_00_00_10010;
      2:  return 15'b0000_11_00_00_00000;
      3:  return 15'b0100_10_00_00_00000;
      4:  return 15'b1000_00_00_00_00000;
      5:  return 15'b0001_00_00_00_00100;
      6:  return 15'b1000_00_00_00_01000;
      7:  return 15'b0100_00_00_10_00000;
      8:  return 15'b0010_00_00_00_00100;
      9:  return 15'b0100_00_01_01_00001;
      10: return 15'b0100_10_00_00_00000;
      11: return 15'b0000_00_00_00_00100;
      12: return 15'b0000_00_10_00_00010;
      default: return 15'b0;
    endcase
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge CLK);
    #1;
    total_cnt++;
    if (State !== 4'd0 || outs !== 15'b0 || PCEn !== 1'b0)
      $display("FAIL reset_hold: state=%0d outs=%b pcen=%b want 0/0/0",
               State, outs, PCEn);
    else pass_cnt++;
    RST = 1'b0;
    total_cnt++;
    if (State !== 4'd0)
      $display("FAIL reset_cycle: state=%0d want 0", State);
    else pass_cnt++;
    step();
    total_cnt++;
    if (State !== 4'd1 || outs !== exp_outs(1))
      $display("FAIL reset_fetch: state=%0d outs=%b want 1/%b",
               State, outs, exp_outs(1));
    else pass_cnt++;
    Opcode = 6'b000000;
    step();
    step();
    total_cnt++;
    if (State !== 4'd7)
      $display("FAIL reset_reach_exec: state=%0d want 7", State);
    else pass_cnt++;
    #2 RST = 1'b1;
    #1;
    total_cnt++;
    if (State !== 4'd0 || outs !== 15'b0 || PCEn !== 1'b0)
      $display("FAIL reset_async: state=%0d outs=%b pcen=%b want 0/0/0",
               State, outs, PCEn);
    else pass_cnt++;
    @(posedge CLK);
    #1 RST = 1'b0;
    total_cnt++;
    if (State !== 4'd0 || outs !== 15'b0)
      $display("FAIL reset_rel: state=%0d outs=%b want 0/0", State, outs);
    else pass_cnt++;
    step();
    total_cnt++;
    if (State !== 4'd1 || outs !== exp_outs(1))
      $display("FAIL reset_refetch: state=%0d outs=%b want 1/%b",
               State, outs, exp_outs(1));
    else pass_cnt++;
  endtask

  task automatic test_lw();
    int seq[5] = '{1, 2, 3, 4, 5};
    Opcode = 6'b100011;
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if (State !== 4'(seq[i]) || outs !== exp_outs(seq[i]))
        $display("FAIL lw_step%0d: state=%0d outs=%b want %0d/%b",
                 i, State, outs, seq[i], exp_outs(seq[i]));
      else pass_cnt++;
      step();
    end
    total_cnt++;
    if (State !== 4'd1)
      $display("FAIL lw_end: state=%0d want 1", State);
    else pass_cnt++;
  endtask

  task automatic test_sw();
    int seq[4] = '{1, 2, 3, 6};
    Opcode = 6'b101011;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (State !== 4'(seq[i]) || outs !== exp_outs(seq[i]))
        $display("FAIL sw_step%0d: state=%0d outs=%b want %0d/%b",
                 i, State, outs, seq[i], exp_outs(seq[i]));
      else pass_cnt++;
      step();
    end
    total_cnt++;
    if (State !== 4'd1 || MemWrite !== 1'b0)
      $display("FAIL sw_end: state=%0d memw=%b want 1/0", State, MemWrite);
    else pass_cnt++;
  endtask

  task automatic test_rtype_addi();
    int rs[4] = '{1, 2, 7, 8};
    int as[4] = '{1, 2, 10, 11};
    Opcode = 6'b000000;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (State !== 4'(rs[i]) || outs !== exp_outs(rs[i]))
        $display("FAIL rtype_step%0d: state=%0d outs=%b want %0d/%b",
                 i, State, outs, rs[i], exp_outs(rs[i]));
      else pass_cnt++;
      step();
    end
    Opcode = 6'b001000;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (State !== 4'(as[i]) || outs !== exp_outs(as[i]))
        $display("FAIL addi_step%0d: state=%0d outs=%b want %0d/%b",
                 i, State, outs, as[i], exp_outs(as[i]));
      else pass_cnt++;
      step();
    end
    total_cnt++;
    if (State !== 4'd1)
      $display("FAIL addi_end: state=%0d want 1", State);
    else pass_cnt++;
  endtask

  task automatic test_beq_j();
    logic [1:0] zv = 2'b10;
    Opcode = 6'b000100;
    for (int k = 0; k < 2; k++) begin
      Zero = zv[1 - k];
      step();
      step();
      total_cnt++;
      if (State !== 4'd9 || outs !== exp_outs(9) || PCEn !== zv[1 - k])
        $display("FAIL beq_z%0d: state=%0d outs=%b pcen=%b want 9/%b/%b",
                 zv[1 - k], State, outs, PCEn, exp_outs(9), zv[1 - k]);
      else pass_cnt++;
      step();
    end
    Zero = 1'b0;
    Opcode = 6'b000010;
    step();
    step();
    total_cnt++;
    if (State !== 4'd12 || outs !== exp_outs(12) || PCEn !== 1'b1)
      $display("FAIL jump: state=%0d outs=%b pcen=%b want 12/%b/1",
               State, outs, PCEn, exp_outs(12));
    else pass_cnt++;
    step();
    total_cnt++;
    if (State !== 4'd1)
      $display("FAIL jump_end: state=%0d want 1", State);
    else pass_cnt++;
  endtask

  task automatic test_illegal();
    Opcode = 6'b111111;
    total_cnt++;
    if (State !== 4'd1 || Illegal !== 1'b0)
      $display("FAIL ill_fetch: state=%0d ill=%b want 1/0", State, Illegal);
    else pass_cnt++;
    step();
    total_cnt++;
    if (State !== 4'd2 || Illegal !== 1'b1 || outs !== exp_outs(2))
      $display("FAIL ill_decode: state=%0d ill=%b outs=%b want 2/1/%b",
               State, Illegal, outs, exp_outs(2));
    else pass_cnt++;
    step();
    total_cnt++;
    if (State !== 4'd1 || Illegal !== 1'b0 || RegWrite !== 1'b0 ||
        MemWrite !== 1'b0)
      $display("FAIL ill_next: state=%0d ill=%b rw=%b mw=%b want 1/0/0/0",
               State, Illegal, RegWrite, MemWrite);
    else pass_cnt++;
  endtask

`ifdef MC_MEM_WAIT_EN
  task automatic test_mem_wait();
    int cyc = 0;
    int stall = 0;
    Opcode = 6'b111111;
    MemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (State !== 4'd1 || PCWrite !== 1'b0 || IRWrite !== 1'b0)
        $display("FAIL fetch_stall%0d: state=%0d pcw=%b irw=%b want 1/0/0",
                 i, State, PCWrite, IRWrite);
      else pass_cnt++;
      step();
    end
    MemReady = 1'b1;
    total_cnt++;
    if (State !== 4'd1 || PCWrite !== 1'b1 || IRWrite !== 1'b1)
      $display("FAIL fetch_go: state=%0d pcw=%b irw=%b want 1/1/1",
               State, PCWrite, IRWrite);
    else pass_cnt++;
    step();
    total_cnt++;
    if (State !== 4'd2 || PCWrite !== 1'b0)
      $display("FAIL fetch_after: state=%0d pcw=%b want 2/0", State, PCWrite);
    else pass_cnt++;
    step();
    Opcode = 6'b100011;
    while (cyc < 20) begin
      if (State == 4'd4 && stall < 2) begin
        MemReady = 1'b0;
        stall++;
      end else begin
        MemReady = 1'b1;
      end
      step();
      cyc++;
      if (State == 4'd1) break;
    end
    MemReady = 1'b1;
    total_cnt++;
    if (cyc !== 7 || stall !== 2)
      $display("FAIL lw_stall_cycles: cycles=%0d stalls=%0d want 7/2",
               cyc, stall);
    else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_rtype_addi();
    test_beq_j();
    test_illegal();
`ifdef MC_MEM_WAIT_EN
    test_mem_wait();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
